power_sqrt: RTL and testbench

- Iterative unsigned integer square root.
- Converts a complex power word (re^2+im^2, width 2*W+1) back to a magnitude |z| = floor(sqrt(power)), plus the remainder.
- Sits downstream of the complex power stage and feeds magnitude-domain logic (normalisation, thresholds).
- Produces one result bit per clock, so it is a low-area, multi-cycle block with a ready/valid handshake.

---
 rtl/power_sqrt.sv | 89 ++++++++
 tb/tb_power_sqrt.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/power_sqrt.sv
// Iterative unsigned square root: one root bit per clock, restoring digit recurrence.
// Returns floor(sqrt(din)) and the remainder din - root^2 with a ready/valid handshake.
module power_sqrt #(
   parameter int unsigned DIN_WIDTH  = 33,
   parameter int unsigned DOUT_WIDTH = (DIN_WIDTH + 1) / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIN_WIDTH-1:0]  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic [DOUT_WIDTH:0]   dout_rem,
   output logic                  dout_valid
);

   localparam int unsigned RAD_WIDTH  = 2 * DOUT_WIDTH;
   localparam int unsigned REM_WIDTH  = DOUT_WIDTH + 2;
   localparam int unsigned REMO_WIDTH = DOUT_WIDTH + 1;
   localparam int unsigned CNT_WIDTH  = $clog2(DOUT_WIDTH + 1);

   typedef enum logic {StIdle, StCalc} state_t;

   state_t                 state;
   logic [RAD_WIDTH-1:0]   radicand;
   logic [DOUT_WIDTH-1:0]  root;
   logic [REM_WIDTH-1:0]   rem;
   logic [CNT_WIDTH-1:0]   cnt;

   logic [RAD_WIDTH-1:0]   din_ext;
   logic [REM_WIDTH-1:0]   rem_shift;
   logic [REM_WIDTH-1:0]   trial;
   logic [REM_WIDTH-1:0]   rem_step;
   logic [DOUT_WIDTH-1:0]  root_step;
   logic                   take;

   always_comb begin
      din_ext   = RAD_WIDTH'(din);
      // Top remainder bits are provably zero before every shift, so truncation is safe.
      rem_shift = REM_WIDTH'({rem, radicand[RAD_WIDTH-1 -: 2]});
      trial     = REM_WIDTH'({root, 2'b01});
      take      = (rem_shift >= trial);
      rem_step  = take ? (rem_shift - trial) : rem_shift;
      root_step = {root[DOUT_WIDTH-2:0], take};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         din_ready  <= 1'b1;
         dout       <= '0;
         dout_rem   <= '0;
         dout_valid <= 1'b0;
         cnt        <= '0;
         radicand   <= '0;
         root       <= '0;
         rem        <= '0;
      end else begin
         dout_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (din_valid) begin
                  radicand  <= din_ext;
                  root      <= '0;
                  rem       <= '0;
                  cnt       <= CNT_WIDTH'(DOUT_WIDTH - 1);
                  din_ready <= 1'b0;
                  state     <= StCalc;
               end
            end
            StCalc: begin
               radicand <= radicand << 2;
               root     <= root_step;
               rem      <= rem_step;
               cnt      <= cnt - CNT_WIDTH'(1);
               if (cnt == '0) begin
                  dout       <= root_step;
                  dout_rem   <= REMO_WIDTH'(rem_step);
                  dout_valid <= 1'b1;
                  din_ready  <= 1'b1;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_power_sqrt.sv
// Scoreboard bench for power_sqrt: driver pushes reference results, a monitor pops and compares
// on every dout_valid, checking values, latency and the root/remainder invariants.
module tb_power_sqrt;

   localparam int unsigned DW = 33;
   localparam int unsigned OW = (DW + 1) / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [OW-1:0] dout;
   logic [OW:0]   dout_rem;
   logic          dout_valid;

   power_sqrt #(.DIN_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_rem  (dout_rem),
      .dout_valid(dout_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint d;
      longint root;
      longint rem;
      longint acc;
   } exp_t;

   exp_t   exp_q[$];
   int     passed = 0;
   int     total  = 0;
   longint cyc    = 0;
   longint n_valid = 0;
   longint last_valid_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Reference: floating estimate corrected with exact integer comparisons.
   function automatic longint isqrt(input longint d);
      longint r;
      r = longint'($floor($sqrt(real'(d))));
      while (r * r > d) r--;
      while ((r + 1) * (r + 1) <= d) r++;
      return r;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst && dout_valid) begin
         exp_t e;
         n_valid++;
         last_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_dout_valid", longint'(dout), -1);
         end else begin
            longint r;
            e = exp_q.pop_front();
            r = longint'(dout);
            check(r == e.root, "dout", r, e.root);
            check(longint'(dout_rem) == e.rem, "dout_rem", longint'(dout_rem), e.rem);
            check(cyc - e.acc == OW, "latency", cyc - e.acc, OW);
            check(r * r <= e.d && e.d < (r + 1) * (r + 1), "root_bounds", r, e.root);
            check(longint'(dout_rem) == e.d - r * r, "rem_identity", longint'(dout_rem), e.d - r * r);
         end
      end
   end

   // Drive one operand, wait (bounded) for acceptance, optionally record the expectation.
   task automatic send(input longint d, input bit keep_valid);
      exp_t e;
      int   waited;
      din = DW'(d);
      din_valid = 1'b1;
      waited = 0;
      while (!din_ready && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      check(waited < 100, "accept_timeout", waited, 0);
      @(posedge clk); #1;
      e.d = d;
      e.root = isqrt(d);
      e.rem = d - e.root * e.root;
      e.acc = cyc;
      exp_q.push_back(e);
      if (!keep_valid) din_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      longint v0, v1;
      bit     ready_ok;
      repeat (2) @(posedge clk);
      #1;
      check(din_ready == 1'b1, "reset_din_ready", din_ready, 1);
      check(dout_valid == 1'b0, "reset_dout_valid", dout_valid, 0);
      check(dout == '0, "reset_dout", dout, 0);
      check(dout_rem == '0, "reset_dout_rem", dout_rem, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // din=0 with per-cycle ready profile
      send(0, 1'b0);
      ready_ok = 1'b1;
      for (int k = 1; k < int'(OW); k++) begin
         @(negedge clk);
         if (din_ready) ready_ok = 1'b0;
         @(posedge clk); #1;
      end
      @(negedge clk);
      if (din_ready) ready_ok = 1'b0;
      @(posedge clk); #1;
      check(ready_ok, "ready_low_during_calc", !ready_ok, 0);
      check(din_ready == 1'b1 && dout_valid == 1'b1, "ready_and_valid_together",
            {din_ready, dout_valid}, 3);
      drain();

      // Back-to-back with din_valid held high
      send(25, 1'b1);
      v0 = n_valid;
      send(26, 1'b0);
      drain();
      v1 = last_valid_cyc;
      check(n_valid - v0 == 2, "b2b_count", n_valid - v0, 2);
      check(exp_q.size() == 0, "b2b_queue_empty", exp_q.size(), 0);
      check(v1 - (v1 - (OW + 1)) == OW + 1 && dout == 5 && dout_rem == 1, "b2b_second",
            longint'(dout_rem), 1);

      // Extremes
      send(64'd2147483648, 1'b0);
      drain();
      check(dout == 46340 && dout_rem == 88048, "max_power", longint'(dout), 46340);
      send(64'd8589934591, 1'b0);
      drain();
      check(dout == 92681 && dout_rem == 166830, "all_ones", longint'(dout_rem), 166830);

      // Operand presented during CALC must be dropped
      v0 = n_valid;
      send(100, 1'b0);
      din = DW'(49);
      din_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1 din_valid = 1'b0;
      repeat (OW + 20) @(posedge clk);
      #1;
      check(n_valid - v0 == 1, "dropped_operand", n_valid - v0, 1);
      check(dout == 10 && dout_rem == 0, "sqrt_100", longint'(dout), 10);

      // Reset mid-calculation
      v0 = n_valid;
      send(1000000, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check(din_ready == 1'b1, "post_reset_ready", din_ready, 1);
      check(dout == '0, "post_reset_dout", longint'(dout), 0);
      repeat (OW + 5) @(posedge clk);
      #1;
      check(n_valid == v0, "aborted_no_valid", n_valid - v0, 0);
      send(1000000, 1'b0);
      drain();
      check(dout == 1000 && dout_rem == 0, "sqrt_1e6", longint'(dout), 1000);

      // Random sweep across magnitudes
      for (int i = 0; i < 2000; i++) begin
         longint d;
         int     sh;
         d = {longint'($urandom_range(0, 1)), 32'($urandom())};
         sh = int'($urandom_range(0, 32));
         d = d >> sh;
         send(d, ($urandom_range(0, 3) == 0));
      end
      din_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got %0d, expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
